reel_result_judge: RTL and testbench
====================================

Name: reel_result_judge

Overview:
- Downstream consumer of the reel state controller's three vertical offsets (0..REEL_H-1, one per reel).
- Gates each spin on available credit, then waits until all three reels have moved and come to rest.
- Quantises each resting offset to a symbol index, judges triple/pair/none and updates a saturating credit counter.
- Outputs drive the start request into the controller (via spin_ok) and the LED/7-seg display path.

Parameters:
- REEL_H, 240, reel strip height in offset units; must be a multiple of SYM_H.
- SYM_H, 60, height of one symbol; REEL_H/SYM_H ≤ 8.
- SETTLE_TICKS, 4, consecutive unchanged ticks required to declare reels stopped.
- TIMEOUT_TICKS, 1023, maximum ticks in SPIN before a forced judge.
- CREDIT_W, 8, credit counter width.
- CREDIT_INIT, 10, credit value after reset.
- TRIPLE_PAY, 5, credit added when all three symbols match.
- PAIR_PAY, 1, credit added when exactly two symbols match.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle enable, asserted when the reel offsets update; all position sampling happens only on tick.
- spin_req  in  1  one-pulse spin request.
- a_pos, b_pos, c_pos  in  10 each  reel offsets.
- spin_ok  out  1  high in IDLE when credit != 0.
- busy  out  1  high whenever the FSM is not in IDLE.
- credit  out  CREDIT_W  current credit.
- a_sym, b_sym, c_sym  out  3 each  judged symbol indices.
- result_valid  out  1  one-cycle pulse when a result is committed.
- win  out  1  triple match; held until the next result or reset.
- pair  out  1  exactly two symbols match; held until the next result or reset.

Behaviour:
- Reset values: credit=CREDIT_INIT; a_sym=b_sym=c_sym=0; result_valid=win=pair=busy=0; FSM=IDLE; all internal counters 0.
- Reset mid-operation aborts any spin with no payout.
- FSM states:
  - IDLE.
    - spin_req with credit≠0: credit−1 on the same edge, clear moved/settle/timeout, go to SPIN.
    - spin_req with credit=0 is ignored.
    - spin_req in any state other than IDLE is ignored.
  - SPIN, updated on each tick:
    - Compare positions with those registered at the previous tick.
    - Any difference: set moved, clear settle_cnt.
    - No difference and moved=1: settle_cnt+1.
    - settle_cnt reaches SETTLE_TICKS: go to JUDGE.
    - timeout_cnt increments on every tick; reaching TIMEOUT_TICKS goes to JUDGE regardless of moved.
    - The previous-position register loads on every tick in all states.
  - JUDGE, one cycle:
    - sym = ((pos + SYM_H/2) mod REEL_H) / SYM_H, i.e. nearest symbol with wrap.
    - The sum is computed at 11 bits.
    - The division is a compare chain; no divider.
    - Register a/b/c_sym.
  - RESULT, one cycle:
    - result_valid=1.
    - win = (a=b=c).
    - pair = !win & (a=b | b=c | a=c).
    - credit += TRIPLE_PAY or PAIR_PAY, saturating at 2^CREDIT_W−1.
    - Return to IDLE.
- Latency: RESULT is entered 2 clk cycles after the settling tick.
- win/pair change only in RESULT.
- Position values ≥ REEL_H are clamped to REEL_H−1 before quantising.

Optional Feature:
- Macro WIN_STREAK_EN.
- Defined:
  - Adds output streak [3:0], reset 0.
  - In RESULT: win increments streak (saturating at 15); a result with neither win nor pair clears it; pair leaves it unchanged.
  - When streak ≥ 3 before increment, the triple payout is 2×TRIPLE_PAY.
- Undefined: no streak port, no streak logic, payout always TRIPLE_PAY.

Decomposition:
- Shared package slot_pkg holds:
  - FSM state typedef {IDLE, SPIN, JUDGE, RESULT};
  - SYM_W=3;
  - default REEL_H/SYM_H;
  - payout constants.
- One sub-module: sym_quant (offset → symbol, combinational, parameterised), instantiated three times.

Test Plan:
- Triple win: reset, then spin_req → credit 9, busy 1. Move reels a few ticks, then hold a=0, b=238, c=1 for 4 ticks → syms 0/0/0, result_valid pulse, win=1, credit 14.
- Pair: with credit 14, rest at a=60, b=61, c=120 → syms 1/1/2, pair=1, win=0, credit 13+1=14.
- No match and credit exhaustion:
  - Repeatedly spin to rest at 0/60/120 → no payout each time.
  - After 10 spins credit=0, spin_ok=0.
  - A further spin_req leaves busy=0 and credit 0.
- Timeout: spin_req with constant positions → JUDGE forced after exactly 1023 ticks, result_valid pulses once.
- Reset mid-SPIN: rst asserted while busy → next cycle IDLE, credit=10, win/pair/result_valid 0, no payout afterwards.
- WIN_STREAK_EN: three consecutive triples → streak 3; fourth triple pays +10; a no-match result → streak 0.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared definitions for the slot-machine result path.
//   - state_t         : judge FSM states (IDLE, SPIN, JUDGE, RESULT)
//   - SYM_W           : width of a symbol index
//   - DEF_REEL_H/SYM_H: default reel strip geometry (offset units)
//   - DEF_*_PAY       : default credit payouts for a triple / pair
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        JUDGE,
        RESULT
    } state_t;

    localparam int SYM_W          = 3;
    localparam int DEF_REEL_H     = 240;
    localparam int DEF_SYM_H      = 60;
    localparam int DEF_TRIPLE_PAY = 5;
    localparam int DEF_PAIR_PAY   = 1;

endpackage

// File: rtl/sym_quant.sv
// Offset-to-symbol quantiser (purely combinational).
// Rounds a reel offset to the nearest symbol, wrapping the top half of the
// last symbol back to symbol 0. Offsets past the strip are clamped to the
// last valid offset first.
// Ports:
//   pos : reel offset, 0..REEL_H-1 nominal (larger values are clamped)
//   sym : symbol index, 0..REEL_H/SYM_H-1
module sym_quant
    import slot_pkg::*;
#(
    parameter int REEL_H = DEF_REEL_H,
    parameter int SYM_H  = DEF_SYM_H
) (
    input  logic [9:0]       pos,
    output logic [SYM_W-1:0] sym
);

    localparam int         NSYM   = REEL_H / SYM_H;
    localparam logic [10:0] RH    = 11'(REEL_H);
    localparam logic [10:0] LAST  = 11'(REEL_H - 1);
    localparam logic [10:0] HALF  = 11'(SYM_H / 2);

    logic [10:0] clamped;
    logic [10:0] sum;
    logic [10:0] wrapped;

    // Nearest-symbol rounding is done by adding half a symbol, folding the
    // result back into the strip, then finding the highest symbol boundary
    // not above it with a compare chain (no divider).
    always_comb begin
        clamped = ({1'b0, pos} >= RH) ? LAST : {1'b0, pos};
        sum     = clamped + HALF;
        wrapped = (sum >= RH) ? (sum - RH) : sum;
        sym     = '0;
        for (int k = 1; k < NSYM; k++) begin
            if (wrapped >= 11'(k * SYM_H)) begin
                sym = SYM_W'(k);
            end
        end
    end

endmodule

// File: rtl/reel_result_judge.sv
// Reel result judge: gates spins on credit, waits for the three reels to move
// and settle, quantises their resting offsets to symbols, judges
// triple/pair/none and updates a saturating credit counter.
// Optional feature macro: WIN_STREAK_EN (adds a win-streak counter and a
// doubled triple payout once the streak reaches 3).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   tick                : reel offset update strobe; positions sampled only on it
//   spin_req            : one-cycle spin request
//   a_pos, b_pos, c_pos : reel offsets
//   spin_ok             : idle with non-zero credit
//   busy                : FSM not idle
//   credit              : current credit
//   a_sym, b_sym, c_sym : judged symbol indices
//   result_valid        : one-cycle pulse while the result is presented
//   win, pair           : triple / exactly-two match, held until next result
//   streak              : (WIN_STREAK_EN only) consecutive-win counter
module reel_result_judge
    import slot_pkg::*;
#(
    parameter int REEL_H        = DEF_REEL_H,
    parameter int SYM_H         = DEF_SYM_H,
    parameter int SETTLE_TICKS  = 4,
    parameter int TIMEOUT_TICKS = 1023,
    parameter int CREDIT_W      = 8,
    parameter int CREDIT_INIT   = 10,
    parameter int TRIPLE_PAY    = DEF_TRIPLE_PAY,
    parameter int PAIR_PAY      = DEF_PAIR_PAY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                spin_req,
    input  logic [9:0]          a_pos,
    input  logic [9:0]          b_pos,
    input  logic [9:0]          c_pos,
    output logic                spin_ok,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [SYM_W-1:0]    a_sym,
    output logic [SYM_W-1:0]    b_sym,
    output logic [SYM_W-1:0]    c_sym,
    output logic                result_valid,
    output logic                win,
    output logic                pair
`ifdef WIN_STREAK_EN
    ,
    output logic [3:0]          streak
`endif
);

    localparam int SETTLE_W  = $clog2(SETTLE_TICKS + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_TICKS - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CREDIT_W-1:0]  CREDIT_MAX   = {CREDIT_W{1'b1}};

`ifdef WIN_STREAK_EN
    localparam logic [3:0] STREAK_MAX      = 4'd15;
    localparam logic [3:0] STREAK_BONUS_AT = 4'd3;
`endif

    state_t                 state;
    logic [9:0]             prev_a;
    logic [9:0]             prev_b;
    logic [9:0]             prev_c;
    logic                   moved;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic [TIMEOUT_W-1:0]   timeout_cnt;

    logic                   pos_changed;
    logic [SYM_W-1:0]       q_a;
    logic [SYM_W-1:0]       q_b;
    logic [SYM_W-1:0]       q_c;
    logic                   is_triple;
    logic                   is_pair;
    logic [CREDIT_W:0]      triple_amt;
    logic [CREDIT_W:0]      pay_amt;
    logic [CREDIT_W:0]      credit_sum;
    logic [CREDIT_W-1:0]    credit_paid;

    // The previous-tick registers hold the resting offsets, so they are what
    // gets quantised in JUDGE (including on a timeout).
    sym_quant #(.REEL_H(REEL_H), .SYM_H(SYM_H)) u_quant_a (.pos(prev_a), .sym(q_a));
    sym_quant #(.REEL_H(REEL_H), .SYM_H(SYM_H)) u_quant_b (.pos(prev_b), .sym(q_b));
    sym_quant #(.REEL_H(REEL_H), .SYM_H(SYM_H)) u_quant_c (.pos(prev_c), .sym(q_c));

    assign pos_changed = (a_pos != prev_a) || (b_pos != prev_b) || (c_pos != prev_c);

    // Judgement and saturating payout are evaluated from the quantiser so that
    // symbols, win/pair, credit and result_valid all become visible together
    // on the edge that enters RESULT.
    always_comb begin
        is_triple = (q_a == q_b) && (q_b == q_c);
        is_pair   = !is_triple && ((q_a == q_b) || (q_b == q_c) || (q_a == q_c));
`ifdef WIN_STREAK_EN
        triple_amt = (streak >= STREAK_BONUS_AT) ? (CREDIT_W+1)'(2 * TRIPLE_PAY)
                                                 : (CREDIT_W+1)'(TRIPLE_PAY);
`else
        triple_amt = (CREDIT_W+1)'(TRIPLE_PAY);
`endif
        pay_amt = '0;
        if (is_triple) begin
            pay_amt = triple_amt;
        end else if (is_pair) begin
            pay_amt = (CREDIT_W+1)'(PAIR_PAY);
        end
        credit_sum  = {1'b0, credit} + pay_amt;
        credit_paid = credit_sum[CREDIT_W] ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
    end

    // Main FSM. busy and spin_ok are kept as registers updated on the same
    // transitions that move the state in and out of IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev_a       <= '0;
            prev_b       <= '0;
            prev_c       <= '0;
            moved        <= 1'b0;
            settle_cnt   <= '0;
            timeout_cnt  <= '0;
            credit       <= CREDIT_W'(CREDIT_INIT);
            a_sym        <= '0;
            b_sym        <= '0;
            c_sym        <= '0;
            result_valid <= 1'b0;
            win          <= 1'b0;
            pair         <= 1'b0;
            busy         <= 1'b0;
            spin_ok      <= (CREDIT_INIT != 0);
`ifdef WIN_STREAK_EN
            streak       <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            if (tick) begin
                prev_a <= a_pos;
                prev_b <= b_pos;
                prev_c <= c_pos;
            end

            case (state)
                IDLE: begin
                    if (spin_req && (credit != '0)) begin
                        credit      <= credit - 1'b1;
                        moved       <= 1'b0;
                        settle_cnt  <= '0;
                        timeout_cnt <= '0;
                        busy        <= 1'b1;
                        spin_ok     <= 1'b0;
                        state       <= SPIN;
                    end
                end

                SPIN: begin
                    if (tick) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        if (pos_changed) begin
                            moved      <= 1'b1;
                            settle_cnt <= '0;
                        end else if (moved) begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                        // Settling only counts once the reels have moved;
                        // the timeout forces a judge either way.
                        if ((!pos_changed && moved && (settle_cnt == SETTLE_LAST)) ||
                            (timeout_cnt == TIMEOUT_LAST)) begin
                            state <= JUDGE;
                        end
                    end
                end

                JUDGE: begin
                    a_sym        <= q_a;
                    b_sym        <= q_b;
                    c_sym        <= q_c;
                    win          <= is_triple;
                    pair         <= is_pair;
                    credit       <= credit_paid;
                    result_valid <= 1'b1;
`ifdef WIN_STREAK_EN
                    if (is_triple) begin
                        if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (!is_pair) begin
                        streak <= '0;
                    end
`endif
                    state <= RESULT;
                end

                RESULT: begin
                    busy    <= 1'b0;
                    spin_ok <= (credit != '0);
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reel_result_judge.sv
// Self-checking bench for reel_result_judge.
// A table of resting positions with hand-computed symbols, win/pair and
// credit drives the main checks; hand-written sequences cover credit
// exhaustion, the spin timeout, reset during a spin and (with WIN_STREAK_EN)
// the win streak. A second instance starting near full credit covers
// payout saturation.
module tb_reel_result_judge;

    localparam int SETTLE_TICKS = 4;

    typedef struct {
        int a;
        int b;
        int c;
        int sa;
        int sb;
        int sc;
        int w;
        int p;
        int cr;
        int st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       spin_req;
    logic [9:0] a_pos;
    logic [9:0] b_pos;
    logic [9:0] c_pos;

    logic       spin_ok, busy, result_valid, win, pair;
    logic [7:0] credit;
    logic [2:0] a_sym, b_sym, c_sym;

    logic       spin_ok_s, busy_s, result_valid_s, win_s, pair_s;
    logic [7:0] credit_s;
    logic [2:0] a_sym_s, b_sym_s, c_sym_s;

`ifdef WIN_STREAK_EN
    logic [3:0] streak;
    logic [3:0] streak_s;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int rv_count = 0;
    int exp_credit = 10;
    vec_t vecs[5];

    reel_result_judge dut (
        .clk(clk), .rst(rst), .tick(tick), .spin_req(spin_req),
        .a_pos(a_pos), .b_pos(b_pos), .c_pos(c_pos),
        .spin_ok(spin_ok), .busy(busy), .credit(credit),
        .a_sym(a_sym), .b_sym(b_sym), .c_sym(c_sym),
        .result_valid(result_valid), .win(win), .pair(pair)
`ifdef WIN_STREAK_EN
        , .streak(streak)
`endif
    );

    reel_result_judge #(.CREDIT_INIT(253)) dut_sat (
        .clk(clk), .rst(rst), .tick(tick), .spin_req(spin_req),
        .a_pos(a_pos), .b_pos(b_pos), .c_pos(c_pos),
        .spin_ok(spin_ok_s), .busy(busy_s), .credit(credit_s),
        .a_sym(a_sym_s), .b_sym(b_sym_s), .c_sym(c_sym_s),
        .result_valid(result_valid_s), .win(win_s), .pair(pair_s)
`ifdef WIN_STREAK_EN
        , .streak(streak_s)
`endif
    );

    always #5 clk = ~clk;

    // Counts result pulses, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (result_valid) rv_count++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input int a, b, c, sa, sb, sc, w, p, cr, st);
        vec_t v;
        v.a = a; v.b = b; v.c = c;
        v.sa = sa; v.sb = sb; v.sc = sc;
        v.w = w; v.p = p; v.cr = cr; v.st = st;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doTick(input int a, input int b, input int c);
        @(negedge clk);
        a_pos = 10'(a);
        b_pos = 10'(b);
        c_pos = 10'(c);
        tick  = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
    endtask

    task automatic pulseSpin();
        @(negedge clk);
        spin_req = 1'b1;
        @(negedge clk);
        spin_req = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full spin: request, a few moving ticks, an ignored mid-spin request,
    // the resting tick plus SETTLE_TICKS unchanged ticks, then the result.
    task automatic applyStimulus(input string tag, input vec_t v);
        pulseSpin();
        checkOutput({tag, " credit after spin"}, int'(credit), exp_credit - 1);
        checkOutput({tag, " busy after spin"}, int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            doTick(5 + 37 * i, 42 + 37 * i, 79 + 37 * i);
        end
        pulseSpin();
        checkOutput({tag, " credit after ignored req"}, int'(credit), exp_credit - 1);
        repeat (SETTLE_TICKS + 1) doTick(v.a, v.b, v.c);
        checkOutput({tag, " result_valid in judge"}, int'(result_valid), 0);
        @(negedge clk);
        checkOutput({tag, " result_valid"}, int'(result_valid), 1);
        checkOutput({tag, " a_sym"}, int'(a_sym), v.sa);
        checkOutput({tag, " b_sym"}, int'(b_sym), v.sb);
        checkOutput({tag, " c_sym"}, int'(c_sym), v.sc);
        checkOutput({tag, " win"}, int'(win), v.w);
        checkOutput({tag, " pair"}, int'(pair), v.p);
        checkOutput({tag, " credit"}, int'(credit), v.cr);
`ifdef WIN_STREAK_EN
        checkOutput({tag, " streak"}, int'(streak), v.st);
`endif
        @(negedge clk);
        checkOutput({tag, " result_valid pulse end"}, int'(result_valid), 0);
        checkOutput({tag, " busy after result"}, int'(busy), 0);
        checkOutput({tag, " spin_ok after result"}, int'(spin_ok), (v.cr != 0) ? 1 : 0);
        exp_credit = v.cr;
    endtask

    initial begin
        int rv_before;
        int guard;
        vec_t nm;

        vecs[0] = mkVec(0,    238, 1,   0, 0, 0, 1, 0, 14, 1);
        vecs[1] = mkVec(60,   61,  120, 1, 1, 2, 0, 1, 14, 1);
        vecs[2] = mkVec(1000, 500, 240, 0, 0, 0, 1, 0, 18, 2);
        vecs[3] = mkVec(89,   90,  150, 1, 2, 3, 0, 0, 17, 0);
        vecs[4] = mkVec(209,  210, 239, 3, 0, 0, 0, 1, 17, 0);

        rst = 1'b1; tick = 1'b0; spin_req = 1'b0;
        a_pos = '0; b_pos = '0; c_pos = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset credit", int'(credit), 10);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset spin_ok", int'(spin_ok), 1);
        checkOutput("reset result_valid", int'(result_valid), 0);
        checkOutput("reset win", int'(win), 0);
        checkOutput("reset pair", int'(pair), 0);
        checkOutput("reset a_sym", int'(a_sym), 0);

        exp_credit = 10;
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
            if (i < 2) begin
                checkOutput($sformatf("vec%0d saturated credit", i), int'(credit_s), 255);
            end
        end

        guard = 0;
        while (exp_credit > 0 && guard < 40) begin
            nm = mkVec(0, 60, 120, 0, 1, 2, 0, 0, exp_credit - 1, 0);
            applyStimulus($sformatf("drain%0d", guard), nm);
            guard++;
        end
        checkOutput("drained credit", int'(credit), 0);
        checkOutput("drained spin_ok", int'(spin_ok), 0);
        pulseSpin();
        repeat (2) @(negedge clk);
        checkOutput("no-credit busy", int'(busy), 0);
        checkOutput("no-credit credit", int'(credit), 0);

        doReset();
        checkOutput("re-reset credit", int'(credit), 10);
        checkOutput("re-reset c_sym", int'(c_sym), 0);
        checkOutput("re-reset b_sym", int'(b_sym), 0);
        checkOutput("re-reset spin_ok", int'(spin_ok), 1);
        exp_credit = 10;

        pulseSpin();
        checkOutput("timeout credit after spin", int'(credit), 9);
        rv_before = rv_count;
        for (int i = 0; i < 1022; i++) doTick(0, 0, 0);
        checkOutput("timeout busy at 1022", int'(busy), 1);
        checkOutput("timeout no early result", rv_count, rv_before);
        doTick(0, 0, 0);
        checkOutput("timeout judge cycle rv", int'(result_valid), 0);
        @(negedge clk);
        checkOutput("timeout result_valid", int'(result_valid), 1);
        checkOutput("timeout win", int'(win), 1);
        checkOutput("timeout credit", int'(credit), 14);
        repeat (3) @(negedge clk);
        checkOutput("timeout single pulse", rv_count, rv_before + 1);

        pulseSpin();
        checkOutput("abort credit after spin", int'(credit), 13);
        doTick(5, 42, 79);
        doTick(100, 100, 100);
        checkOutput("abort busy before reset", int'(busy), 1);
        rv_before = rv_count;
        doReset();
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort credit", int'(credit), 10);
        checkOutput("abort win", int'(win), 0);
        checkOutput("abort pair", int'(pair), 0);
        checkOutput("abort result_valid", int'(result_valid), 0);
        repeat (SETTLE_TICKS + 2) doTick(100, 100, 100);
        checkOutput("abort no result", rv_count, rv_before);
        checkOutput("abort credit held", int'(credit), 10);
        checkOutput("abort busy held", int'(busy), 0);

`ifdef WIN_STREAK_EN
        exp_credit = 10;
        applyStimulus("streak1", mkVec(0, 238, 1, 0, 0, 0, 1, 0, 14, 1));
        applyStimulus("streak2", mkVec(0, 238, 1, 0, 0, 0, 1, 0, 18, 2));
        applyStimulus("streak3", mkVec(0, 238, 1, 0, 0, 0, 1, 0, 22, 3));
        applyStimulus("streak4", mkVec(0, 238, 1, 0, 0, 0, 1, 0, 31, 4));
        applyStimulus("streak clear", mkVec(0, 60, 120, 0, 1, 2, 0, 0, 30, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
